// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and shared types for the timing generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_H_SYNC_END  = 96;
  localparam int DEF_V_SYNC_END  = 2;
  localparam int DEF_H_ACT_START = 144;
  localparam int DEF_H_ACT_END   = 784;
  localparam int DEF_V_ACT_START = 35;
  localparam int DEF_V_ACT_END   = 515;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hSync;
    logic vSync;
    logic bright;
  } syncState_t;

  // Half-open window test [lo, hi) done at counter width.
  function automatic logic inRange(cnt_t value, cnt_t lo, cnt_t hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of the VGA generator; master drives, slave (pixel pipeline) observes.
// frameCount exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  cnt_t hCount;
  cnt_t vCount;
  logic bright;
  logic hSync;
  logic vSync;
  logic pixTick;
  logic frameStart;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frameCount;
`endif

  modport master (
    output hCount, vCount, bright, hSync, vSync, pixTick, frameStart
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frameCount
`endif
  );

  modport slave (
    input hCount, vCount, bright, hSync, vSync, pixTick, frameStart
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frameCount
`endif
  );

endinterface

// File: rtl/vga_pixel_clken.sv
// Pixel clock enable: divides clk by CLK_DIV and pulses pixTick on the last divider phase.
module vga_pixel_clken
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic pixTick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt <= '0;
    end else if (divCnt == DIV_LAST) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  // Gated by reset so the pulse stays low in reset even when CLK_DIV is 1.
  assign pixTick = reset && (divCnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters with sync, active-window and frame markers.
// Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit wrapping frameCount output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int H_SYNC_END  = DEF_H_SYNC_END,
  parameter int V_SYNC_END  = DEF_V_SYNC_END,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT_END   = DEF_H_ACT_END,
  parameter int V_ACT_START = DEF_V_ACT_START,
  parameter int V_ACT_END   = DEF_V_ACT_END
) (
  input  logic            clk,
  input  logic            reset,
  vga_timing_gen_if.master vga
);

  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYNC  = cnt_t'(H_SYNC_END);
  localparam cnt_t V_SYNC  = cnt_t'(V_SYNC_END);
  localparam cnt_t H_ACT_S = cnt_t'(H_ACT_START);
  localparam cnt_t H_ACT_E = cnt_t'(H_ACT_END);
  localparam cnt_t V_ACT_S = cnt_t'(V_ACT_START);
  localparam cnt_t V_ACT_E = cnt_t'(V_ACT_END);

  cnt_t       hCount;
  cnt_t       vCount;
  logic       pixTick;
  logic       hWrap;
  logic       vWrap;
  logic       frameStart;
  syncState_t syncNow;

  vga_pixel_clken #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clken (
    .clk     (clk),
    .reset   (reset),
    .pixTick (pixTick)
  );

  assign hWrap      = (hCount == H_LAST);
  assign vWrap      = (vCount == V_LAST);
  assign frameStart = pixTick && hWrap && vWrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hCount <= '0;
    end else if (pixTick) begin
      hCount <= hWrap ? '0 : hCount + cnt_t'(1);
    end
  end

  // The line counter only moves on the pixel tick that ends a line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vCount <= '0;
    end else if (pixTick && hWrap) begin
      vCount <= vWrap ? '0 : vCount + cnt_t'(1);
    end
  end

  // Decoded straight from the registered counters so they never lag them.
  always_comb begin
    syncNow        = '0;
    syncNow.hSync  = (hCount >= H_SYNC);
    syncNow.vSync  = (vCount >= V_SYNC);
    syncNow.bright = inRange(hCount, H_ACT_S, H_ACT_E) && inRange(vCount, V_ACT_S, V_ACT_E);
  end

  assign vga.hCount     = hCount;
  assign vga.vCount     = vCount;
  assign vga.hSync      = syncNow.hSync;
  assign vga.vSync      = syncNow.vSync;
  assign vga.bright     = syncNow.bright;
  assign vga.pixTick    = pixTick;
  assign vga.frameStart = frameStart;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frameCount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frameCount <= '0;
    end else if (frameStart) begin
      frameCount <= frameCount + 16'd1;
    end
  end

  assign vga.frameCount = frameCount;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down instance sweeps whole frames, a default instance covers the first lines.
module tb_vga_timing_gen;

  localparam int EXP_W = 41;

  // Scaled timing so several full frames fit in a short run.
  localparam int S_D   = 4;
  localparam int S_HT  = 40;
  localparam int S_VT  = 12;
  localparam int S_HSE = 5;
  localparam int S_VSE = 2;
  localparam int S_HAS = 8;
  localparam int S_HAE = 36;
  localparam int S_VAS = 3;
  localparam int S_VAE = 10;

  // Standard 640x480 timing.
  localparam int D_D   = 4;
  localparam int D_HT  = 800;
  localparam int D_VT  = 525;
  localparam int D_HSE = 96;
  localparam int D_VSE = 2;
  localparam int D_HAS = 144;
  localparam int D_HAE = 784;
  localparam int D_VAS = 35;
  localparam int D_VAE = 515;

  logic clk;
  logic reset;

  vga_timing_gen_if vgaS ();
  vga_timing_gen_if vgaD ();

  vga_timing_gen #(
    .CLK_DIV     (S_D),
    .H_TOTAL     (S_HT),
    .V_TOTAL     (S_VT),
    .H_SYNC_END  (S_HSE),
    .V_SYNC_END  (S_VSE),
    .H_ACT_START (S_HAS),
    .H_ACT_END   (S_HAE),
    .V_ACT_START (S_VAS),
    .V_ACT_END   (S_VAE)
  ) dutS (
    .clk   (clk),
    .reset (reset),
    .vga   (vgaS)
  );

  vga_timing_gen dutD (
    .clk   (clk),
    .reset (reset),
    .vga   (vgaD)
  );

  logic [15:0] fcS;
  logic [15:0] fcD;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign fcS = vgaS.frameCount;
  assign fcD = vgaD.frameCount;
`else
  assign fcS = '0;
  assign fcD = '0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since the last reset release: the model's time base.
  int unsigned k = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected outputs after k edges, from pixel arithmetic alone.
  function automatic logic [EXP_W-1:0] model(input int unsigned edges, input int d, input int ht,
                                             input int vt, input int hse, input int vse,
                                             input int has, input int hae, input int vas,
                                             input int vae);
    int unsigned p;
    int unsigned h;
    int unsigned v;
    logic b, hs, vs, pt, fs;
    int unsigned fc;
    p  = edges / d;
    h  = p % ht;
    v  = (p / ht) % vt;
    b  = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
    hs = (h >= hse);
    vs = (v >= vse);
    pt = (edges % d) == d - 1;
    fs = pt && ((p % (ht * vt)) == ht * vt - 1);
    fc = (p / (ht * vt)) % 65536;
    return {10'(h), 10'(v), b, hs, vs, pt, fs, 16'(fc)};
  endfunction

  task automatic compareVga(input string pfx, input logic [EXP_W-1:0] e, input logic [9:0] h,
                            input logic [9:0] v, input logic b, input logic hs, input logic vs,
                            input logic pt, input logic fs, input logic [15:0] fc);
    check({pfx, ".hCount"},     int'(h),  int'(e[40:31]));
    check({pfx, ".vCount"},     int'(v),  int'(e[30:21]));
    check({pfx, ".bright"},     int'(b),  int'(e[20]));
    check({pfx, ".hSync"},      int'(hs), int'(e[19]));
    check({pfx, ".vSync"},      int'(vs), int'(e[18]));
    check({pfx, ".pixTick"},    int'(pt), int'(e[17]));
    check({pfx, ".frameStart"}, int'(fs), int'(e[16]));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check({pfx, ".frameCount"}, int'(fc), int'(e[15:0]));
`endif
  endtask

  task automatic checkAll();
    exp_q.push_back(model(k, S_D, S_HT, S_VT, S_HSE, S_VSE, S_HAS, S_HAE, S_VAS, S_VAE));
    exp_q.push_back(model(k, D_D, D_HT, D_VT, D_HSE, D_VSE, D_HAS, D_HAE, D_VAS, D_VAE));
    compareVga("S", exp_q.pop_front(), vgaS.hCount, vgaS.vCount, vgaS.bright, vgaS.hSync,
               vgaS.vSync, vgaS.pixTick, vgaS.frameStart, fcS);
    compareVga("D", exp_q.pop_front(), vgaD.hCount, vgaD.vCount, vgaD.bright, vgaD.hSync,
               vgaD.vSync, vgaD.pixTick, vgaD.frameStart, fcD);
  endtask

  // ---------------- driver tasks ----------------
  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkAll();
    end
  endtask

  // Asserts reset between edges, confirms the outputs clear without waiting for a clock.
  task automatic pulseReset(input int holdCycles);
    #($urandom_range(1, 4));
    reset = 1'b0;
    #1;
    compareVga("S.async", '0, vgaS.hCount, vgaS.vCount, vgaS.bright, vgaS.hSync, vgaS.vSync,
               vgaS.pixTick, vgaS.frameStart, fcS);
    compareVga("D.async", '0, vgaD.hCount, vgaD.vCount, vgaD.bright, vgaD.hSync, vgaD.vSync,
               vgaD.pixTick, vgaD.frameStart, fcD);
    runCycles(holdCycles);
    #2;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    runCycles(2);
    #2;
    reset = 1'b1;

    // Long stretch: several scaled frames and the first default line wrap.
    runCycles(5000);

    for (int i = 0; i < 6; i++) begin
      runCycles($urandom_range(60, 2400));
      pulseReset($urandom_range(1, 3));
    end

    // Enough scaled frames after the last reset to see frameCount reach 3 and beyond.
    runCycles(4 * S_D * S_HT * S_VT + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per pixel (100 MHz clk to 25 MHz pixel rate).
REQ-002 SHALL have parameter H_TOTAL, default 800: pixels per line.
REQ-003 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-004 SHALL have parameter H_SYNC_END, default 96: hSync is low while hCount < H_SYNC_END.
REQ-005 SHALL have parameter V_SYNC_END, default 2: vSync is low while vCount < V_SYNC_END.
REQ-006 SHALL have parameters H_ACT_START/H_ACT_END, defaults 144/784: active columns are [start, end).
REQ-007 SHALL have parameters V_ACT_START/V_ACT_END, defaults 35/515: active rows are [start, end).
REQ-008 SHALL have port clk, input, 1: single system clock; all logic is on posedge.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port hCount, output, 10: current pixel column, 0..H_TOTAL-1.
REQ-011 SHALL have port vCount, output, 10: current line, 0..V_TOTAL-1.
REQ-012 SHALL have port bright, output, 1: high inside the active window.
REQ-013 SHALL have port hSync, output, 1: active-low horizontal sync.
REQ-014 SHALL have port vSync, output, 1: active-low vertical sync.
REQ-015 SHALL have port pixTick, output, 1: one-clk pulse on the clk in which the counters advance.
REQ-016 SHALL have port frameStart, output, 1: one-clk pulse when the counters wrap to (0,0).

Function
REQ-017 SHALL use a divider counter 0..CLK_DIV-1 that increments every clk and wraps to 0; pixTick SHALL be high in the clk where the divider equals CLK_DIV-1.
REQ-018 SHALL increment hCount on pixTick; hCount = H_TOTAL-1 on pixTick SHALL wrap to 0 and increment vCount.
REQ-019 SHALL wrap vCount = V_TOTAL-1 to 0 when hCount also wraps; frameStart SHALL be high in that same clk only.
REQ-020 SHALL derive hSync, vSync and bright combinationally from the registered hCount/vCount (zero latency, always aligned with the counters).
REQ-021 SHALL drive bright = (H_ACT_START <= hCount < H_ACT_END) AND (V_ACT_START <= vCount < V_ACT_END).
REQ-022 SHALL hold hCount and vCount constant between pixTicks, for exactly CLK_DIV clks per pixel.
REQ-023 SHALL perform all compares at 10-bit width; parameters SHALL satisfy H_TOTAL, V_TOTAL <= 1024 and each *_END <= its TOTAL.

Reset
REQ-024 While reset=0: divider=0, hCount=0, vCount=0, pixTick=0, frameStart=0, hSync=0, vSync=0, bright=0.
REQ-025 Reset asserted mid-frame SHALL clear the state immediately (asynchronously); after release, the first pixTick SHALL come on the CLK_DIV-th clk edge.

Configuration
REQ-026 With VGA_TIMING_FRAME_CNT_EN defined, the block SHALL add output frameCount[15:0], reset to 0, which increments on every frameStart and wraps from 65535 to 0.
REQ-027 Without VGA_TIMING_FRAME_CNT_EN, the frameCount port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package vga_timing_pkg SHALL hold the default timing constants (800, 525, 96, 2, 144, 784, 35, 515, 4) and the 10-bit count width.
REQ-029 The divider SHALL be a sub-module vga_pixel_clken (clk, reset -> pixTick); hCount/vCount logic SHALL stay in the top module.

Verification
REQ-030 Reset released at t0 -> hCount=0 for clks 1-3; pixTick on clk 4; hCount=1 from clk 4 onward.
REQ-031 hCount=799 at vCount=10 when pixTick fires -> next clk hCount=0 and vCount=11, with no frameStart.
REQ-032 (799,524) at pixTick -> (0,0) with frameStart high for exactly 1 clk; period between frameStarts = 800*525*4 = 1,680,000 clks.
REQ-033 Sync checks over one line/frame -> hSync low at hCount 0..95 and high at 96..799; vSync low at vCount 0..1 and high otherwise.
REQ-034 bright checks -> 0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,515).
REQ-035 reset pulsed at (400,200) -> all outputs 0 at once; with VGA_TIMING_FRAME_CNT_EN, frameCount=0 and then reads 3 after three frameStarts.
